// File: rtl/wingen_pkg.sv
// Shared constants and types for the 3x3 window generator.
package wingen_pkg;

    localparam int unsigned DEF_IMG_W = 400;
    localparam int unsigned DEF_IMG_H = 300;
    localparam int unsigned DEF_PIX_W = 8;

    localparam int unsigned COORD_W    = 10;
    localparam int unsigned WIN_TAPS   = 9;
    localparam int unsigned WIN_CENTRE = 4;

    typedef enum logic {
        ACTIVE     = 1'b0,
        FRAME_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/wingen_line_buffer.sv
// One line of pixel storage: registered read, write lands after the read on a shared address.
module wingen_line_buffer
    import wingen_pkg::*;
#(
    parameter  int unsigned DEPTH = DEF_IMG_W,
    parameter  int unsigned WIDTH = DEF_PIX_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 window generator over a blanked raster stream, two line buffers deep.
// Define WINGEN_COORD_EN to add the out_col/out_row window-centre ports.
module window_3x3_gen
    import wingen_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PIX_W-1:0]     in_data,
    input  logic                 in_valid,
    input  logic                 in_blank,
    output logic [9*PIX_W-1:0]   win,
    output logic                 out_valid,
    output logic                 sync_err
`ifdef WINGEN_COORD_EN
    ,
    output logic [COORD_W-1:0]   out_col,
    output logic [COORD_W-1:0]   out_row
`endif
);

    localparam int unsigned        AW       = $clog2(IMG_W);
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] ROW_END  = COORD_W'(IMG_H);

    state_t               state;
    logic [COORD_W-1:0]   col, row, row_nxt;
    logic [COORD_W-1:0]   beat_col, beat_row;
    logic                 act_beat, blank_beat;

    assign act_beat   = in_valid & ~in_blank;
    assign blank_beat = in_valid & in_blank;
    assign row_nxt    = row + 1'b1;

    // An active beat in FRAME_DONE is taken as pixel (0,0) of the next frame.
    assign beat_col = (state == FRAME_DONE) ? '0 : col;
    assign beat_row = (state == FRAME_DONE) ? '0 : row;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ACTIVE;
            col      <= '0;
            row      <= '0;
            sync_err <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (act_beat) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row_nxt;
                            if (row_nxt == ROW_END)
                                state <= FRAME_DONE;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else if (blank_beat && col != '0) begin
                        sync_err <= 1'b1;
                        col      <= '0;
                        row      <= row_nxt;
                        if (row_nxt == ROW_END)
                            state <= FRAME_DONE;
                    end
                end
                FRAME_DONE: begin
                    if (blank_beat) begin
                        col   <= '0;
                        row   <= '0;
                        state <= ACTIVE;
                    end else if (act_beat) begin
                        sync_err <= 1'b1;
                        col      <= COORD_W'(1);
                        row      <= '0;
                        state    <= ACTIVE;
                    end
                end
                default: state <= ACTIVE;
            endcase
        end
    end

    logic                 v_s1;
    logic [PIX_W-1:0]     pix_s1;
    logic [COORD_W-1:0]   col_s1, row_s1;

    always_ff @(posedge clock) begin
        if (reset) begin
            v_s1   <= 1'b0;
            pix_s1 <= '0;
            col_s1 <= '0;
            row_s1 <= '0;
        end else begin
            v_s1 <= act_beat;
            if (act_beat) begin
                pix_s1 <= in_data;
                col_s1 <= beat_col;
                row_s1 <= beat_row;
            end
        end
    end

    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    wingen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb0 (
        .clock   (clock),
        .rd_en   (act_beat),
        .rd_addr (beat_col[AW-1:0]),
        .rd_data (lb0_rd),
        .wr_en   (v_s1),
        .wr_addr (col_s1[AW-1:0]),
        .wr_data (pix_s1)
    );

    wingen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb1 (
        .clock   (clock),
        .rd_en   (act_beat),
        .rd_addr (beat_col[AW-1:0]),
        .rd_data (lb1_rd),
        .wr_en   (v_s1),
        .wr_addr (col_s1[AW-1:0]),
        .wr_data (lb0_rd)
    );

    logic [WIN_TAPS-1:0][PIX_W-1:0] win_q;

    // Each row drops its left tap; the new column enters at j=2 (rows oldest to newest).
    always_ff @(posedge clock) begin
        if (reset) begin
            win_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v_s1 && (row_s1 >= COORD_W'(2)) && (col_s1 >= COORD_W'(2));
            if (v_s1)
                win_q <= {pix_s1, win_q[8], win_q[7],
                          lb0_rd, win_q[5], win_q[4],
                          lb1_rd, win_q[2], win_q[1]};
        end
    end

    assign win = win_q;

`ifdef WINGEN_COORD_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            out_col <= '0;
            out_row <= '0;
        end else if (v_s1) begin
            out_col <= col_s1 - 1'b1;
            out_row <= row_s1 - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a reduced frame geometry.
module tb_window_3x3_gen;

    localparam int W  = 16;
    localparam int H  = 10;
    localparam int HB = 4;
    localparam int VB = 2;
    localparam int PW = 8;

    logic         clock = 1'b0;
    logic         reset, in_valid, in_blank;
    logic [7:0]   in_data;
    logic [71:0]  win;
    logic         out_valid, sync_err;
`ifdef WINGEN_COORD_EN
    logic [9:0]   out_col, out_row;
`endif

    always #5 clock = ~clock;

    window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_blank  (in_blank),
        .win       (win),
        .out_valid (out_valid),
        .sync_err  (sync_err)
`ifdef WINGEN_COORD_EN
        ,
        .out_col   (out_col),
        .out_row   (out_row)
`endif
    );

    typedef struct packed {
        logic        v;
        logic        wk;
        logic [9:0]  c;
        logic [9:0]  r;
        logic [71:0] w;
    } exp_t;

    exp_t cur_exp, p1, p2;

    // Expected window info travels two clocks, matching the documented latency.
    always @(posedge clock) begin
        if (reset) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= cur_exp;
            p2 <= p1;
        end
    end

    int          total = 0;
    int          bad   = 0;
    int          win_total = 0;
    int          base;
    bit          first_seen;
    logic [71:0] first_w;
    logic [9:0]  first_c, first_r, last_c, last_r;
    logic [7:0]  img   [H][W];
    bit          known [H][W];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic [7:0] d, input exp_t e);
        in_valid = v;
        in_blank = b;
        in_data  = d;
        cur_exp  = e;
        @(negedge clock);
        chk("out_valid", {71'd0, out_valid}, {71'd0, p2.v});
        if (p2.v && p2.wk)
            chk("win", win, p2.w);
`ifdef WINGEN_COORD_EN
        if (p2.v) begin
            chk("out_col", {62'd0, out_col}, 72'(p2.c - 10'd1));
            chk("out_row", {62'd0, out_row}, 72'(p2.r - 10'd1));
        end
`endif
        if (out_valid === 1'b1) begin
            win_total++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_w    = win;
                first_c    = p2.c - 10'd1;
                first_r    = p2.r - 10'd1;
            end
`ifdef WINGEN_COORD_EN
            if (first_seen && win_total == base + 1) begin
                first_c = out_col;
                first_r = out_row;
            end
            last_c = out_col;
            last_r = out_row;
`else
            last_c = p2.c - 10'd1;
            last_r = p2.r - 10'd1;
`endif
        end
        @(posedge clock);
        #1;
        cur_exp  = '0;
        in_valid = 1'b0;
        in_blank = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, '0);
    endtask

    task automatic blank();
        cycle(1'b1, 1'b1, 8'hA5, '0);
    endtask

    task automatic pixel(input int r, input int c, input logic [7:0] d);
        exp_t e;
        img[r][c]   = d;
        known[r][c] = 1'b1;
        e    = '0;
        e.v  = (r >= 2 && c >= 2);
        e.wk = e.v;
        e.c  = 10'(c);
        e.r  = 10'(r);
        if (e.v) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if (!known[r-2+i][c-2+j])
                        e.wk = 1'b0;
                    e.w[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
                end
            end
        end
        cycle(1'b1, 1'b0, d, e);
    endtask

    task automatic clear_known();
        foreach (known[i, j])
            known[i][j] = 1'b0;
    endtask

    // One ramp frame; short_row gets one pixel fewer, tail=0 omits all trailing blanking.
    task automatic frame(input int holes, input int short_row, input bit tail);
        int n;
        clear_known();
        base       = win_total;
        first_seen = 1'b0;
        for (int r = 0; r < H; r++) begin
            n = (r == short_row) ? W - 1 : W;
            for (int c = 0; c < n; c++) begin
                for (int k = 0; k < 8 && $urandom_range(0, 99) < holes; k++)
                    idle();
                pixel(r, c, 8'((r + c) & 255));
            end
            if (r < H - 1 || tail)
                repeat (HB) blank();
        end
        if (tail)
            repeat (VB * (W + HB)) blank();
        repeat (3) idle();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_blank = 1'b0;
        in_data  = '0;
        cur_exp  = '0;
        clear_known();
        repeat (3) idle();
        reset = 1'b0;
        chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
        chk("rst_sync_err",  {71'd0, sync_err},  72'd0);
        chk("rst_win",       win,                72'd0);

        // Gap-free ramp frame
        frame(0, -1, 1'b1);
        chk("a_count",    72'(win_total - base), 72'((W - 2) * (H - 2)));
        chk("a_sync_err", {71'd0, sync_err}, 72'd0);
        chk("a_first_centre", {64'd0, first_w[39:32]}, 72'd2);
        chk("a_first_tl",     {64'd0, first_w[7:0]},   72'd0);
        chk("a_first_col", {62'd0, first_c}, 72'd1);
        chk("a_first_row", {62'd0, first_r}, 72'd1);
        chk("a_last_col",  {62'd0, last_c},  72'(W - 2));
        chk("a_last_row",  {62'd0, last_r},  72'(H - 2));

        // Same frame with 30% holes
        frame(30, -1, 1'b1);
        chk("b_count",    72'(win_total - base), 72'((W - 2) * (H - 2)));
        chk("b_sync_err", {71'd0, sync_err}, 72'd0);

        // Row 3 one pixel short: its last-column window never happens
        frame(0, 3, 1'b1);
        chk("c_count",    72'(win_total - base), 72'((W - 2) * (H - 2) - 1));
        chk("c_sync_err", {71'd0, sync_err}, 72'd1);

        // Reset right after a window-producing beat
        clear_known();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < W; c++)
                pixel(r, c, 8'((r + c) & 255));
        for (int c = 0; c < 5; c++)
            pixel(2, c, 8'((2 + c) & 255));
        reset = 1'b1;
        idle();
        chk("mid_rst_out_valid", {71'd0, out_valid}, 72'd0);
        chk("mid_rst_sync_err",  {71'd0, sync_err},  72'd0);
        chk("mid_rst_win",       win,                72'd0);
        idle();
        idle();
        reset = 1'b0;

        // Fresh frame after reset, ending without any blanking
        frame(0, -1, 1'b0);
        chk("d_count",    72'(win_total - base), 72'((W - 2) * (H - 2)));
        chk("d_sync_err", {71'd0, sync_err}, 72'd0);

        // Active beat arrives in FRAME_DONE: taken as (0,0)
        frame(0, -1, 1'b1);
        chk("e_count",    72'(win_total - base), 72'((W - 2) * (H - 2)));
        chk("e_sync_err", {71'd0, sync_err}, 72'd1);
        chk("e_first_centre", {64'd0, first_w[39:32]}, 72'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
